// File: rtl/dma_apb_initiator_if.sv
// Job request and APB write bus bundle for dma_apb_initiator.
// master: the initiator side; slave: the job source / APB target side.
interface dma_apb_initiator_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  job_valid;
  logic                  job_ready;
  logic [DATA_WIDTH-1:0] job_src;
  logic [DATA_WIDTH-1:0] job_dst;
  logic [DATA_WIDTH-1:0] job_size;
  logic                  busy;
  logic                  done;
  logic [1:0]            err;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic                  INTR;

  modport master (
    input  job_valid, job_src, job_dst, job_size,
    input  PREADY, INTR,
    output job_ready, busy, done, err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output job_valid, job_src, job_dst, job_size,
    output PREADY, INTR,
    input  job_ready, busy, done, err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/dma_apb_initiator.sv
// APB write initiator: programs SRC/DEST/SIZE/MODE, waits for INTR,
// clears INT and reports done/err. All outputs come straight from flops.
module dma_apb_initiator #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int INTR_TIMEOUT   = 1024,
  parameter int PREADY_TIMEOUT = 64
) (
  input logic                  CLK,
  input logic                  RST,
  dma_apb_initiator_if.master  bus
);

  localparam int MAX_T = (INTR_TIMEOUT > PREADY_TIMEOUT) ?
                         INTR_TIMEOUT : PREADY_TIMEOUT;
  localparam int CW = $clog2(MAX_T + 1);

  localparam logic [CW-1:0] PT_LAST = CW'(PREADY_TIMEOUT - 1);
  localparam logic [CW-1:0] IT_LAST = CW'(INTR_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE, SETUP, ACCESS, WAIT_INTR, DONE
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            seq_q, seq_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [1:0]            status_q, status_d;
  logic                  accept;
  logic                  psel_d;
  logic [DATA_WIDTH-1:0] src_q, dst_q, size_q;
  logic [DATA_WIDTH-1:0] src_d, dst_d, size_d;
  logic [DATA_WIDTH-1:0] wdata_d;

  logic                  psel_q, pen_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  busy_q, ready_q, done_q;
  logic [1:0]            err_q;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    seq_d    = seq_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    accept   = 1'b0;
    unique case (state_q)
      IDLE: begin
        status_d = 2'b00;
        cnt_d    = '0;
        seq_d    = '0;
        if (bus.job_valid) begin
          accept = 1'b1;
          if (bus.job_size == '0) begin
            state_d  = DONE;
            status_d = 2'b11;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (bus.PREADY) begin
          cnt_d = '0;
          if (seq_q == 3'd4) begin
            state_d = DONE;
          end else if (seq_q == 3'd3) begin
            state_d = WAIT_INTR;
          end else begin
            state_d = SETUP;
            seq_d   = seq_q + 3'd1;
          end
        end else if (cnt_q >= PT_LAST) begin
          cnt_d    = '0;
          state_d  = DONE;
          status_d = 2'b10;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_INTR: begin
        // On timeout the INT clear is still written so MODE drops to 0
        if (bus.INTR || cnt_q >= IT_LAST) begin
          cnt_d   = '0;
          seq_d   = 3'd4;
          state_d = SETUP;
          if (!bus.INTR) status_d = 2'b01;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign src_d  = accept ? bus.job_src  : src_q;
  assign dst_d  = accept ? bus.job_dst  : dst_q;
  assign size_d = accept ? bus.job_size : size_q;
  assign psel_d = (state_d == SETUP) || (state_d == ACCESS);

  always_comb begin
    wdata_d = DATA_WIDTH'(1);
    unique case (1'b1)
      seq_d == 3'd0: wdata_d = src_d;
      seq_d == 3'd1: wdata_d = dst_d;
      seq_d == 3'd2: wdata_d = size_d;
      default:       wdata_d = DATA_WIDTH'(1);
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      seq_q    <= '0;
      cnt_q    <= '0;
      status_q <= 2'b00;
      src_q    <= '0;
      dst_q    <= '0;
      size_q   <= '0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      seq_q    <= seq_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      size_q   <= size_d;
      psel_q   <= psel_d;
      pen_q    <= (state_d == ACCESS);
      paddr_q  <= psel_d ? ADDR_WIDTH'({seq_d, 2'b00}) : '0;
      pwdata_q <= psel_d ? wdata_d : '0;
      busy_q   <= (state_d != IDLE);
      ready_q  <= (state_d == IDLE);
      done_q   <= (state_d == DONE);
      err_q    <= (state_d == DONE) ? status_d : 2'b00;
    end
  end

  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = pen_q;
  assign bus.PWRITE    = psel_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.busy      = busy_q;
  assign bus.job_ready = ready_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: doc/dma_apb_initiator.md
Name: dma_apb_initiator

Overview:
- APB write initiator that programs the DMA register block and services its completion interrupt.
- Accepts one transfer job (src, dst, size) on a valid/ready interface.
- Issues APB writes in this order: SRC, DEST, SIZE, MODE=1. It then waits for INTR, writes INT to clear, and reports done/err.
- Sits between the job-issuing controller and the DMA's APB slave port.

Parameters:
- ADDR_WIDTH, 32, PADDR width
- DATA_WIDTH, 32, PWDATA and job field width
- INTR_TIMEOUT, 1024, maximum cycles spent in WAIT_INTR before error
- PREADY_TIMEOUT, 64, maximum cycles spent in ACCESS before error

Ports:
- CLK  in  1  clock; all logic on posedge
- RST  in  1  synchronous, active-high reset
- job_valid  in  1  job request
- job_ready  out  1  high only in IDLE
- job_src  in  DATA_WIDTH  source address
- job_dst  in  DATA_WIDTH  destination address
- job_size  in  DATA_WIDTH  transfer size
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end
- err  out  2  status, valid while done=1: 00 ok, 01 INTR timeout, 10 PREADY timeout, 11 zero size
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  always 1 while PSEL=1, else 0
- PADDR  out  ADDR_WIDTH  register address
- PWDATA  out  DATA_WIDTH  register write data
- PREADY  in  1  slave ready
- INTR  in  1  DMA completion interrupt

Behaviour:
- Reset (RST high at posedge): state=IDLE, seq_idx=0, counter=0. Outputs: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, done=0, err=00, busy=0. job_ready=1 from the cycle after reset release.
- RST asserted mid-job aborts the job at the next edge, including during ACCESS. No done pulse is issued.
- Accept: job_valid & job_ready at an edge latches src/dst/size.
  - size≠0: go to SETUP with seq_idx=0.
  - size=0: go to DONE with err=11 and no APB traffic.
- Write sequence (seq_idx → PADDR / PWDATA):
  - 0 → 0x00 / src
  - 1 → 0x04 / dst
  - 2 → 0x08 / size
  - 3 → 0x0C / 32'h1
  - 4 → 0x10 / 32'h1
- All outputs are registered.
- SETUP: PSEL=1, PENABLE=0, PWRITE=1, PADDR/PWDATA valid. Lasts exactly 1 cycle, then ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PADDR/PWDATA held stable. Counter increments each cycle.
  - PREADY=1 at an edge completes the write and clears the counter. PSEL/PENABLE drop at that edge unless the next write follows.
  - After seq_idx 0–2: SETUP with seq_idx+1.
  - After seq_idx 3: WAIT_INTR.
  - After seq_idx 4: DONE.
  - No PREADY after PREADY_TIMEOUT cycles in ACCESS: drop PSEL/PENABLE, go to DONE with err=10. The INT clear write is not attempted.
  - Back-to-back writes have no idle cycle between ACCESS and the next SETUP.
- WAIT_INTR: PSEL=0. INTR is sampled only in this state; INTR high during the write phase is ignored.
  - INTR=1 at an edge: go to SETUP with seq_idx=4, err=00. INTR high on the first WAIT_INTR cycle is accepted.
  - INTR_TIMEOUT cycles elapse without INTR: set err=01 and go to SETUP with seq_idx=4. The INT clear is still written so MODE returns to 0.
- DONE: done=1 for exactly 1 cycle, err held that cycle, then IDLE. err returns to 00 in IDLE. No new job is accepted during DONE.
- Timing with a zero-wait slave (PREADY=1 on the first ACCESS cycle): each write takes 2 cycles. With the DMA's registered PREADY, each write takes 3 cycles.
- Counters saturate and cannot wrap. Counter width is $clog2(max(INTR_TIMEOUT, PREADY_TIMEOUT)+1).

Test Plan:
- Zero-wait slave, job src=0x0010_0000, dst=0x0000_0040, size=4; INTR pulsed 5 cycles after the MODE write.
  - Required: APB writes 0x00←0x00100000, 0x04←0x40, 0x08←4, 0x0C←1, then 0x10←1.
  - Each write has a 1-cycle SETUP and a 1-cycle ACCESS. done=1 with err=00.
- Slave with PREADY delayed 1 cycle (the DMA's registered PREADY): every ACCESS lasts 2 cycles, PADDR/PWDATA stay stable throughout, the same 5 writes occur, and done has err=00.
- INTR held low, INTR_TIMEOUT=16: exactly 16 cycles in WAIT_INTR, then the 0x10←1 write, then done with err=01.
- PREADY stuck low, PREADY_TIMEOUT=8 on the SRC write: ACCESS lasts 8 cycles, PSEL drops, done has err=10, and no further writes occur.
- job_size=0: done pulses 1 cycle after accept with err=11, and PSEL stays 0.
- RST asserted during the ACCESS of the SIZE write: PSEL=0, busy=0 and job_ready=1 after the edge, no done pulse; the next job runs normally.
